kbd_matrix: RTL and testbench
=============================

# kbd_matrix

Holds the Vector-06C keyboard matrix state, fed by a PS/2 scancode byte stream. The block parses F0/E0 prefixes and tracks the СС/УС/РУС modifiers. For every ordinary scancode it sequences a lookup through `scan2matrix`, which has a 2-cycle registered ROM path, then sets or clears one bit of an 8×8 key matrix. The PPI keyboard port reads that matrix back through active-low row select / column sense.

## Interface
Parameters:
- SHIFT_L, 8'h12, left shift scancode
- SHIFT_R, 8'h59, right shift scancode
- CTRL_CODE, 8'h14, maps to УС
- RUS_CODE, 8'h58, caps lock, maps to РУС/LAT (momentary)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- scan_data  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe, scan_data valid
- busy  out  1  lookup sequence in progress
- overrun  out  1  sticky; a byte arrived while busy; cleared only by reset
- s2m_scancode  out  8  registered address to scan2matrix
- s2m_shift  out  1  registered mod_shift to scan2matrix
- s2m_row, s2m_col  in  3 each  qrow/qcol from scan2matrix
- s2m_xshift  in  1  qshift: key needs inverted Vector shift
- s2m_error  in  1  qerror: no mapping
- rowsel  in  8  PPI row select, active-low
- cols  out  8  column sense, active-low
- key_ss, key_us, key_rus  out  1 each  modifier lines, active-high pressed

## Operation
- Prefix flags `brk` (F0) and `ext` (E0) are set on their byte and cleared after the next non-prefix byte is consumed.
- Byte E1, AA, FA, FE, EE: ignored; both flags cleared.
- Byte 00 or FF (keyboard overrun): matrix, xshift state and modifiers are cleared.
- E0 12 and E0 59 (fake shifts): dropped.
- Modifiers never go through scan2matrix:
  - SHIFT_L / SHIFT_R set or clear the phys_l / phys_r bits.
  - CTRL_CODE, with or without E0, drives key_us.
  - RUS_CODE drives key_rus.
- Any other byte starts a lookup; E0 on these is otherwise ignored.
- FSM states: IDLE, LOOK, WAIT, APPLY, LOOK2, WAIT2, APPLY2.
- Make:
  - IDLE→LOOK: s2m_scancode←byte, s2m_shift←phys_l|phys_r.
  - LOOK→WAIT→APPLY: sample s2m_*. If s2m_error=0, set matrix[row][col]. If s2m_xshift=1, set xs_valid and store xs_pos={row,col}.
  - APPLY→IDLE.
- Break (the shift state may have changed since the make, so both table entries are cleared):
  - LOOK uses s2m_shift=0. APPLY clears that position (unless error), then goes to LOOK2.
  - LOOK2 uses s2m_shift=1. APPLY2 clears that position, then goes to IDLE.
  - Clearing a position equal to xs_pos while xs_valid is set also clears xs_valid.
- key_ss = (phys_l|phys_r) XOR xs_valid.
- cols[c] = ~OR over r with rowsel[r]=0 of matrix[r][c]. cols is combinational from registered state; rowsel=FF gives cols=FF.
- Reset: matrix=0, flags=0, xs_valid=0, phys_l=phys_r=0, overrun=0, busy=0, s2m_scancode=00, s2m_shift=0, state=IDLE, cols=FF, key_*=0. Reset mid-sequence aborts the sequence with the same values.

## Timing
- s2m_scancode and s2m_shift update on the edge that enters LOOK/LOOK2. s2m_* inputs are sampled in APPLY/APPLY2, exactly 2 cycles later.
- busy is high from the cycle after a scan_valid that starts a lookup until the last APPLY cycle inclusive.
  - Make: 3 cycles busy.
  - Break: 6 cycles busy.
- Prefix, modifier and ignored bytes are absorbed in 1 cycle; busy stays 0.
- scan_valid while busy: the byte is dropped and overrun is set.
- The matrix bit changes on the APPLY edge, so cols reflects it one cycle after APPLY.

## Structure
- Shared package `kbd_pkg`:
  - scancode constants F0, E0, E1, AA, FA, FE, EE, 00, FF;
  - modifier defaults;
  - FSM state encoding.
- One combinational sub-module, `kbd_colmux`, takes the 64-bit matrix and rowsel and produces cols.
- scan2matrix is instantiated by the parent, not inside this block.

## Test plan
- Make 1C with stub row=4, col=1: busy 3 cycles. rowsel=EF → cols=FD; rowsel=FF → cols=FF.
- F0 1C after that make: busy 6 cycles, with s2m_shift 0 then 1. cols returns to FF.
- Shift make (12), then 52 with stub xshift=1, row=2, col=7: key_ss=0 while held (1 XOR 1). F0 52 → key_ss=1.
- 76 then FF: matrix cleared, cols=FF for every rowsel.
- scan_valid on the 2nd busy cycle: byte ignored, overrun=1, matrix shows only the first key.
- Reset asserted in WAIT: next cycle busy=0, s2m_scancode=00, cols=FF, all key_*=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants, FSM state encoding and helpers for the Vector-06C keyboard matrix.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVR1   = 8'hFF;

    localparam logic [7:0] DEF_SHIFT_L = 8'h12;
    localparam logic [7:0] DEF_SHIFT_R = 8'h59;
    localparam logic [7:0] DEF_CTRL    = 8'h14;
    localparam logic [7:0] DEF_RUS     = 8'h58;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOK,
        ST_WAIT,
        ST_APPLY,
        ST_LOOK2,
        ST_WAIT2,
        ST_APPLY2
    } kbd_state_t;

    typedef enum logic [2:0] {
        BK_BREAK,
        BK_EXT,
        BK_IGNORE,
        BK_OVERRUN,
        BK_FAKE_SHIFT,
        BK_MODIFIER,
        BK_LOOKUP
    } byte_kind_t;

    // Flat matrix bit index: row-major, 8 columns per row.
    function automatic logic [5:0] mat_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/kbd_colmux.sv
// Column sense: a column reads low when any selected (low) row has that key pressed.
module kbd_colmux
    import kbd_pkg::*;
(
    input  logic [63:0] matrix,
    input  logic [7:0]  rowsel,
    output logic [7:0]  cols
);

    always_comb begin
        cols = '1;
        for (int unsigned r = 0; r < 8; r++) begin
            if (!rowsel[r]) begin
                cols = cols & ~matrix[mat_idx(3'(r), 3'd0) +: 8];
            end
        end
    end

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 scancode stream to Vector-06C 8x8 key matrix, with modifier tracking and
// a sequenced lookup through an external registered scan2matrix ROM.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter logic [7:0] SHIFT_L   = DEF_SHIFT_L,
    parameter logic [7:0] SHIFT_R   = DEF_SHIFT_R,
    parameter logic [7:0] CTRL_CODE = DEF_CTRL,
    parameter logic [7:0] RUS_CODE  = DEF_RUS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_data,
    input  logic       scan_valid,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] s2m_scancode,
    output logic       s2m_shift,
    input  logic [2:0] s2m_row,
    input  logic [2:0] s2m_col,
    input  logic       s2m_xshift,
    input  logic       s2m_error,
    input  logic [7:0] rowsel,
    output logic [7:0] cols,
    output logic       key_ss,
    output logic       key_us,
    output logic       key_rus
);

    kbd_state_t state, next_state;
    byte_kind_t kind;

    logic        brk, ext, op_brk;
    logic [63:0] matrix;
    logic        xs_valid;
    logic [5:0]  xs_pos;
    logic        phys_l, phys_r, us, rus;
    logic        accept;
    logic [5:0]  apply_pos;
    logic        xs_hit;

    assign accept    = scan_valid && (state == ST_IDLE);
    assign apply_pos = mat_idx(s2m_row, s2m_col);
    assign xs_hit    = xs_valid && (xs_pos == apply_pos);

    always_comb begin
        kind = BK_LOOKUP;
        if (scan_data == SC_BREAK) begin
            kind = BK_BREAK;
        end else if (scan_data == SC_EXT) begin
            kind = BK_EXT;
        end else if (scan_data == SC_PAUSE || scan_data == SC_BAT_OK || scan_data == SC_ACK ||
                     scan_data == SC_RESEND || scan_data == SC_ECHO) begin
            kind = BK_IGNORE;
        end else if (scan_data == SC_OVR0 || scan_data == SC_OVR1) begin
            kind = BK_OVERRUN;
        end else if (ext && (scan_data == SHIFT_L || scan_data == SHIFT_R)) begin
            kind = BK_FAKE_SHIFT;
        end else if (scan_data == SHIFT_L || scan_data == SHIFT_R ||
                     scan_data == CTRL_CODE || scan_data == RUS_CODE) begin
            kind = BK_MODIFIER;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept && kind == BK_LOOKUP) next_state = ST_LOOK;
            ST_LOOK:   next_state = ST_WAIT;
            ST_WAIT:   next_state = ST_APPLY;
            ST_APPLY:  next_state = op_brk ? ST_LOOK2 : ST_IDLE;
            ST_LOOK2:  next_state = ST_WAIT2;
            ST_WAIT2:  next_state = ST_APPLY2;
            ST_APPLY2: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brk          <= 1'b0;
            ext          <= 1'b0;
            op_brk       <= 1'b0;
            matrix       <= '0;
            xs_valid     <= 1'b0;
            xs_pos       <= '0;
            phys_l       <= 1'b0;
            phys_r       <= 1'b0;
            us           <= 1'b0;
            rus          <= 1'b0;
            overrun      <= 1'b0;
            s2m_scancode <= '0;
            s2m_shift    <= 1'b0;
        end else begin
            if (scan_valid && state != ST_IDLE) overrun <= 1'b1;

            if (accept) begin
                if (kind != BK_BREAK && kind != BK_EXT) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
                case (kind)
                    BK_BREAK: brk <= 1'b1;
                    BK_EXT:   ext <= 1'b1;
                    BK_OVERRUN: begin
                        matrix   <= '0;
                        xs_valid <= 1'b0;
                        phys_l   <= 1'b0;
                        phys_r   <= 1'b0;
                        us       <= 1'b0;
                        rus      <= 1'b0;
                    end
                    BK_MODIFIER: begin
                        if      (scan_data == SHIFT_L)   phys_l <= ~brk;
                        else if (scan_data == SHIFT_R)   phys_r <= ~brk;
                        else if (scan_data == CTRL_CODE) us     <= ~brk;
                        else                             rus    <= ~brk;
                    end
                    BK_LOOKUP: begin
                        s2m_scancode <= scan_data;
                        s2m_shift    <= ~brk & (phys_l | phys_r);
                        op_brk       <= brk;
                    end
                    default: ;
                endcase
            end

            // Break releases both table entries: unshifted first, then shifted.
            if (state == ST_APPLY) begin
                if (op_brk) s2m_shift <= 1'b1;
                if (!s2m_error) begin
                    if (!op_brk) begin
                        matrix[apply_pos] <= 1'b1;
                        if (s2m_xshift) begin
                            xs_valid <= 1'b1;
                            xs_pos   <= apply_pos;
                        end
                    end else begin
                        matrix[apply_pos] <= 1'b0;
                        if (xs_hit) xs_valid <= 1'b0;
                    end
                end
            end

            if (state == ST_APPLY2 && !s2m_error) begin
                matrix[apply_pos] <= 1'b0;
                if (xs_hit) xs_valid <= 1'b0;
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign key_ss  = (phys_l | phys_r) ^ xs_valid;
    assign key_us  = us;
    assign key_rus = rus;

    kbd_colmux u_colmux (
        .matrix (matrix),
        .rowsel (rowsel),
        .cols   (cols)
    );

endmodule

// File: tb/tb_kbd_matrix.sv
// Self-checking bench for kbd_matrix with a two-stage registered scan2matrix stub.
module tb_kbd_matrix;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       busy, overrun;
    logic [7:0] s2m_scancode;
    logic       s2m_shift;
    logic [2:0] s2m_row, s2m_col;
    logic       s2m_xshift, s2m_error;
    logic [7:0] rowsel;
    logic [7:0] cols;
    logic       key_ss, key_us, key_rus;

    int checks = 0;
    int failures = 0;
    int tmo_cnt = 0;
    int run = 0;

    logic [8:0] exp_addr_q[$];
    logic [8:0] obs_addr_q[$];
    int         exp_len_q[$];
    int         obs_len_q[$];

    always #5 clk = ~clk;

    kbd_matrix #(
        .SHIFT_L   (8'h12),
        .SHIFT_R   (8'h59),
        .CTRL_CODE (8'h14),
        .RUS_CODE  (8'h58)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_data    (scan_data),
        .scan_valid   (scan_valid),
        .busy         (busy),
        .overrun      (overrun),
        .s2m_scancode (s2m_scancode),
        .s2m_shift    (s2m_shift),
        .s2m_row      (s2m_row),
        .s2m_col      (s2m_col),
        .s2m_xshift   (s2m_xshift),
        .s2m_error    (s2m_error),
        .rowsel       (rowsel),
        .cols         (cols),
        .key_ss       (key_ss),
        .key_us       (key_us),
        .key_rus      (key_rus)
    );

    typedef struct packed {
        logic       err;
        logic       xs;
        logic [2:0] row;
        logic [2:0] col;
    } map_t;

    function automatic map_t stub_map(input logic [7:0] code, input logic shift);
        map_t m;
        m = '0;
        case (code)
            8'h1C: begin m.row = 3'd4; m.col = 3'd1; end
            8'h52: begin m.row = 3'd2; m.col = 3'd7; m.xs = 1'b1; end
            8'h76: begin m.row = 3'd0; m.col = 3'd5; end
            8'h2B: begin m.row = 3'd1; m.col = shift ? 3'd2 : 3'd1; end
            default: m.err = 1'b1;
        endcase
        return m;
    endfunction

    map_t stage1 = '0;
    map_t stage2 = '0;
    always @(posedge clk) begin
        stage1 <= stub_map(s2m_scancode, s2m_shift);
        stage2 <= stage1;
    end
    assign s2m_row    = stage2.row;
    assign s2m_col    = stage2.col;
    assign s2m_xshift = stage2.xs;
    assign s2m_error  = stage2.err;

    // Observe lookup addresses at busy cycles 1 and 4, and the busy run length.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run++;
            if (run == 1 || run == 4) obs_addr_q.push_back({s2m_scancode, s2m_shift});
        end else if (run > 0) begin
            obs_len_q.push_back(run);
            run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_data  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) tmo_cnt++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        scan_valid = 1'b0;
        scan_data  = 8'h00;
        rowsel     = 8'h00;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, overrun, s2m_shift} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {busy, overrun, s2m_shift}); end
        checks++; if (s2m_scancode !== 8'h00) begin failures++;
            $display("FAIL reset_scancode got=%h exp=00", s2m_scancode); end
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL reset_cols got=%h exp=FF", cols); end
        checks++; if ({key_ss, key_us, key_rus} !== 3'b000) begin failures++;
            $display("FAIL reset_keys got=%b exp=000", {key_ss, key_us, key_rus}); end
        reset = 1'b0;
        @(negedge clk);
        exp_addr_q.delete(); obs_addr_q.delete(); exp_len_q.delete(); obs_len_q.delete();
    endtask

    task automatic drain(input string tag);
        logic [8:0] ea, oa;
        int el, ol;
        while (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 9'h1FF;
            checks++; if (oa !== ea) begin failures++;
                $display("FAIL %s_addr got={%h,%b} exp={%h,%b}", tag, oa[8:1], oa[0], ea[8:1], ea[0]); end
        end
        while (exp_len_q.size() > 0) begin
            el = exp_len_q.pop_front();
            ol = (obs_len_q.size() > 0) ? obs_len_q.pop_front() : -1;
            checks++; if (ol !== el) begin failures++;
                $display("FAIL %s_busy_len got=%0d exp=%0d", tag, ol, el); end
        end
        checks++; if (obs_addr_q.size() + obs_len_q.size() + tmo_cnt !== 0) begin failures++;
            $display("FAIL %s_extra got=%0d/%0d/%0d exp=0/0/0", tag,
                     obs_addr_q.size(), obs_len_q.size(), tmo_cnt); end
        obs_addr_q.delete(); obs_len_q.delete(); tmo_cnt = 0;
    endtask

    task automatic test_make();
        exp_len_q.push_back(3); exp_addr_q.push_back({8'h1C, 1'b0});
        send_byte(8'h1C);
        wait_idle();
        rowsel = 8'hEF; #1;
        checks++; if (cols !== 8'hFD) begin failures++;
            $display("FAIL make_cols_row4 got=%h exp=FD", cols); end
        rowsel = 8'hFF; #1;
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL make_cols_none got=%h exp=FF", cols); end
        rowsel = 8'hFE; #1;
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL make_cols_row0 got=%h exp=FF", cols); end
        drain("make");
    endtask

    task automatic test_break();
        send_byte(8'hF0);
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL break_prefix_busy got=%b exp=0", busy); end
        exp_len_q.push_back(6);
        exp_addr_q.push_back({8'h1C, 1'b0}); exp_addr_q.push_back({8'h1C, 1'b1});
        send_byte(8'h1C);
        wait_idle();
        rowsel = 8'hEF; #1;
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL break_cols got=%h exp=FF", cols); end
        drain("break");
    endtask

    task automatic test_xshift();
        send_byte(8'h12);
        checks++; if (key_ss !== 1'b1) begin failures++;
            $display("FAIL xs_shift_held got=%b exp=1", key_ss); end
        exp_len_q.push_back(3); exp_addr_q.push_back({8'h52, 1'b1});
        send_byte(8'h52);
        wait_idle();
        checks++; if (key_ss !== 1'b0) begin failures++;
            $display("FAIL xs_key_held got=%b exp=0", key_ss); end
        rowsel = 8'hFB; #1;
        checks++; if (cols !== 8'h7F) begin failures++;
            $display("FAIL xs_cols got=%h exp=7F", cols); end
        exp_len_q.push_back(6);
        exp_addr_q.push_back({8'h52, 1'b0}); exp_addr_q.push_back({8'h52, 1'b1});
        send_byte(8'hF0);
        send_byte(8'h52);
        wait_idle();
        checks++; if (key_ss !== 1'b1) begin failures++;
            $display("FAIL xs_key_released got=%b exp=1", key_ss); end
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL xs_cols_released got=%h exp=FF", cols); end
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++; if (key_ss !== 1'b0) begin failures++;
            $display("FAIL xs_shift_released got=%b exp=0", key_ss); end
        drain("xshift");
    endtask

    task automatic test_shift_table();
        send_byte(8'h12);
        exp_len_q.push_back(3); exp_addr_q.push_back({8'h2B, 1'b1});
        send_byte(8'h2B);
        wait_idle();
        rowsel = 8'hFD; #1;
        checks++; if (cols !== 8'hFB) begin failures++;
            $display("FAIL shtab_cols got=%h exp=FB", cols); end
        send_byte(8'hF0);
        send_byte(8'h12);
        exp_len_q.push_back(6);
        exp_addr_q.push_back({8'h2B, 1'b0}); exp_addr_q.push_back({8'h2B, 1'b1});
        send_byte(8'hF0);
        send_byte(8'h2B);
        wait_idle();
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL shtab_cols_released got=%h exp=FF", cols); end
        drain("shtab");
    endtask

    task automatic test_modifiers();
        send_byte(8'h14);
        checks++; if (key_us !== 1'b1) begin failures++;
            $display("FAIL mod_us_make got=%b exp=1", key_us); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        checks++; if (key_us !== 1'b0) begin failures++;
            $display("FAIL mod_us_ext_break got=%b exp=0", key_us); end
        send_byte(8'h58);
        checks++; if (key_rus !== 1'b1) begin failures++;
            $display("FAIL mod_rus_make got=%b exp=1", key_rus); end
        send_byte(8'hE0); send_byte(8'h12);
        checks++; if ({key_ss, busy} !== 2'b00) begin failures++;
            $display("FAIL mod_fake_shift got=%b exp=00", {key_ss, busy}); end
        send_byte(8'h12);
        checks++; if (key_ss !== 1'b1) begin failures++;
            $display("FAIL mod_shift_after_fake got=%b exp=1", key_ss); end
        send_byte(8'hF0); send_byte(8'hAA); send_byte(8'h14);
        checks++; if (key_us !== 1'b1) begin failures++;
            $display("FAIL mod_ignore_clears_brk got=%b exp=1", key_us); end
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'hF0); send_byte(8'h14);
        send_byte(8'hF0); send_byte(8'h58);
        checks++; if ({key_ss, key_us, key_rus} !== 3'b000) begin failures++;
            $display("FAIL mod_all_released got=%b exp=000", {key_ss, key_us, key_rus}); end
        drain("mod");
    endtask

    task automatic test_kbd_overrun();
        exp_len_q.push_back(3); exp_addr_q.push_back({8'h76, 1'b0});
        send_byte(8'h76);
        wait_idle();
        rowsel = 8'hFE; #1;
        checks++; if (cols !== 8'hDF) begin failures++;
            $display("FAIL ovr_cols_before got=%h exp=DF", cols); end
        send_byte(8'h12);
        send_byte(8'h14);
        send_byte(8'hFF);
        checks++; if ({key_ss, key_us} !== 2'b00) begin failures++;
            $display("FAIL ovr_mods got=%b exp=00", {key_ss, key_us}); end
        for (int r = 0; r < 9; r++) begin
            rowsel = (r == 8) ? 8'h00 : ~(8'h01 << r); #1;
            checks++; if (cols !== 8'hFF) begin failures++;
                $display("FAIL ovr_cols rowsel=%h got=%h exp=FF", rowsel, cols); end
        end
        drain("kbdovr");
    endtask

    task automatic test_busy_drop();
        checks++; if (overrun !== 1'b0) begin failures++;
            $display("FAIL drop_overrun_before got=%b exp=0", overrun); end
        exp_len_q.push_back(3); exp_addr_q.push_back({8'h1C, 1'b0});
        send_byte(8'h1C);
        @(negedge clk);
        scan_data  = 8'h76;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        wait_idle();
        checks++; if (overrun !== 1'b1) begin failures++;
            $display("FAIL drop_overrun got=%b exp=1", overrun); end
        rowsel = 8'hEF; #1;
        checks++; if (cols !== 8'hFD) begin failures++;
            $display("FAIL drop_first_key got=%h exp=FD", cols); end
        rowsel = 8'hFE; #1;
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL drop_second_key got=%h exp=FF", cols); end
        drain("drop");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h12);
        send_byte(8'h58);
        exp_len_q.push_back(2); exp_addr_q.push_back({8'h1C, 1'b1});
        send_byte(8'h1C);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rowsel = 8'h00; #1;
        checks++; if ({busy, overrun, s2m_shift} !== 3'b000) begin failures++;
            $display("FAIL rstmid_flags got=%b exp=000", {busy, overrun, s2m_shift}); end
        checks++; if (s2m_scancode !== 8'h00) begin failures++;
            $display("FAIL rstmid_scancode got=%h exp=00", s2m_scancode); end
        checks++; if (cols !== 8'hFF) begin failures++;
            $display("FAIL rstmid_cols got=%h exp=FF", cols); end
        checks++; if ({key_ss, key_us, key_rus} !== 3'b000) begin failures++;
            $display("FAIL rstmid_keys got=%b exp=000", {key_ss, key_us, key_rus}); end
        reset = 1'b0;
        wait_idle();
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_xshift();
        test_shift_table();
        test_modifiers();
        test_kbd_overrun();
        test_busy_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
